// File: rtl/mcu_link_pkg.sv
// mcu_link_pkg: MCU->ROCSTAR cable code words, lock-state type, pending-trig
// entry layout and small code-word classification helpers.
package mcu_link_pkg;

    // Code words; these must stay bit-identical to the MCU transmitter.
    localparam logic [3:0] IDLE0 = 4'b0111;
    localparam logic [3:0] IDLE1 = 4'b1011;
    localparam logic [3:0] IDLE2 = 4'b1101;
    localparam logic [3:0] IDLE3 = 4'b1110;
    localparam logic [3:0] NCOIN = 4'b1001;
    localparam logic [3:0] PCOIN = 4'b0011;

    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } lock_state_t;

    // Widest trig tag an entry can carry; narrower tags are zero-extended.
    localparam int unsigned TAGW_MAX = 32;

    typedef struct packed {
        logic [15:0]         ts;
        logic [TAGW_MAX-1:0] tag;
    } pend_entry_t;

    function automatic logic is_idle(input logic [3:0] w);
        return (w == IDLE0) || (w == IDLE1) || (w == IDLE2) || (w == IDLE3);
    endfunction

    function automatic logic is_reply(input logic [3:0] w);
        return (w == PCOIN) || (w == NCOIN);
    endfunction

    function automatic logic is_code_word(input logic [3:0] w);
        return is_idle(w) || is_reply(w);
    endfunction

    // Successor in the rotating idle pattern (only meaningful for idles).
    function automatic logic [3:0] idle_succ(input logic [3:0] w);
        logic [3:0] n;
        case (w)
            IDLE0:   n = IDLE1;
            IDLE1:   n = IDLE2;
            IDLE2:   n = IDLE3;
            default: n = IDLE0;
        endcase
        return n;
    endfunction

    function automatic logic valid_transition(input logic [3:0] prev, input logic [3:0] cur);
        logic ok;
        if (is_idle(prev)) begin
            ok = (cur == idle_succ(prev)) || is_reply(cur);
        end else if (is_reply(prev)) begin
            ok = (cur == IDLE0);
        end else begin
            ok = 1'b0;
        end
        return ok;
    endfunction

endpackage

// File: rtl/reply_fifo.sv
// reply_fifo: synchronous FIFO of pending trigs. A pop in the same cycle as
// a push while full frees the slot the push needs, so both are honoured.
module reply_fifo #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned W     = 24
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic         full,
    output logic         empty,
    output logic [W-1:0] head
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [AW:0]   count;
    logic          do_pop;
    logic          do_push;

    // Qualify requests against current occupancy.
    always_comb begin
        full    = (count == (AW+1)'(DEPTH));
        empty   = (count == '0);
        do_pop  = pop && !empty;
        do_push = push && (!full || do_pop);
        head    = mem[rd_ptr];
    end

    // Storage write; contents need no reset since empty masks them.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/mcu_reply_rx.sv
// mcu_reply_rx: receives the 4-bit MCU cable stream, acquires lock on the
// rotating idle pattern and resolves every locally issued trig to exactly
// one of accept / reject / timeout.
// Optional build macro: MCU_REPLY_STATS_EN enables the statistics counters
// and cnt_clr; otherwise the counter outputs are tied to zero.
module mcu_reply_rx
    import mcu_link_pkg::*;
#(
    parameter int unsigned REPLY_LAT = 6,
    parameter int unsigned REPLY_TOL = 1,
    parameter int unsigned DEPTH     = 8,
    parameter int unsigned TAGW      = 8,
    parameter int unsigned LOCK_N    = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [3:0]      mcu_in,
    input  logic            trig,
    input  logic [TAGW-1:0] trig_tag,
    input  logic            cnt_clr,
    output logic            locked,
    output logic            accept,
    output logic            reject,
    output logic            timeout,
    output logic [TAGW-1:0] res_tag,
    output logic            ovf,
    output logic [15:0]     code_err_cnt,
    output logic [15:0]     unsol_cnt,
    output logic [15:0]     timeout_cnt
);

    localparam logic [15:0] WIN_LO     = 16'(REPLY_LAT - REPLY_TOL);
    localparam logic [15:0] WIN_HI     = 16'(REPLY_LAT + REPLY_TOL);
    localparam logic [15:0] EXPIRE_AGE = 16'(REPLY_LAT + REPLY_TOL + 1);
    localparam int unsigned CW         = $clog2(LOCK_N + 1);
    localparam int unsigned EW         = 16 + TAGW;

    logic [3:0]    word_q;
    logic [3:0]    prev_q;
    logic          word_vld;
    logic          prev_vld;
    logic [15:0]   ts;

    lock_state_t   lock_state;
    lock_state_t   lock_state_nxt;
    logic [CW-1:0] lock_cnt;
    logic [CW-1:0] lock_cnt_nxt;

    logic          xfer_ok;
    logic          code_err;
    logic          reply_dec;
    logic          reply_hit;
    logic          expire;
    logic          pop_req;
    logic          ovf_nxt;
    logic [15:0]   age;

    logic [EW-1:0] push_data;
    logic [EW-1:0] head_bits;
    logic          fifo_full;
    logic          fifo_empty;
    pend_entry_t   head_ent;
    logic          unused_tag_hi;

    // Capture the cable word, keep its predecessor, run the timestamp.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            word_q   <= '0;
            prev_q   <= '0;
            word_vld <= 1'b0;
            prev_vld <= 1'b0;
            ts       <= '0;
        end else begin
            word_q   <= mcu_in;
            prev_q   <= word_q;
            word_vld <= 1'b1;
            prev_vld <= word_vld;
            ts       <= ts + 16'd1;
        end
    end

    // Entries are stamped with the ts value that follows the trig edge, so
    // age counts capture edges between the trig and the reply word.
    always_comb begin
        push_data = {ts + 16'd1, trig_tag};
    end

    reply_fifo #(
        .DEPTH (DEPTH),
        .W     (EW)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (trig),
        .pop   (pop_req),
        .din   (push_data),
        .full  (fifo_full),
        .empty (fifo_empty),
        .head  (head_bits)
    );

    // Decode the captured word, compare head age to the reply window.
    always_comb begin
        head_ent.ts  = head_bits[EW-1:TAGW];
        head_ent.tag = TAGW_MAX'(head_bits[TAGW-1:0]);
        age          = ts - head_ent.ts;
        xfer_ok      = word_vld && is_code_word(word_q)
                       && (!prev_vld || valid_transition(prev_q, word_q));
        code_err     = word_vld && !xfer_ok;
        reply_dec    = (lock_state == LOCKED) && xfer_ok && is_reply(word_q);
        reply_hit    = reply_dec && !fifo_empty && (age >= WIN_LO) && (age <= WIN_HI);
        expire       = !fifo_empty && (age == EXPIRE_AGE) && !reply_hit;
        pop_req      = reply_hit || expire;
        ovf_nxt      = trig && fifo_full && !pop_req;
    end

    assign unused_tag_hi = |(head_ent.tag >> TAGW);

    // Lock FSM state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lock_state <= HUNT;
            lock_cnt   <= '0;
        end else begin
            lock_state <= lock_state_nxt;
            lock_cnt   <= lock_cnt_nxt;
        end
    end

    // Lock FSM next state: count consecutive valid words in HUNT.
    always_comb begin
        lock_state_nxt = lock_state;
        lock_cnt_nxt   = lock_cnt;
        if (word_vld) begin
            case (lock_state)
                HUNT: begin
                    if (code_err) begin
                        lock_cnt_nxt = '0;
                    end else if (lock_cnt == CW'(LOCK_N - 1)) begin
                        lock_state_nxt = LOCKED;
                        lock_cnt_nxt   = '0;
                    end else begin
                        lock_cnt_nxt = lock_cnt + CW'(1);
                    end
                end
                default: begin
                    if (code_err) begin
                        lock_state_nxt = HUNT;
                        lock_cnt_nxt   = '0;
                    end
                end
            endcase
        end
    end

    // Lock FSM output.
    always_comb begin
        locked = (lock_state == LOCKED);
    end

    // Registered resolution pulses and resolved tag.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            accept  <= 1'b0;
            reject  <= 1'b0;
            timeout <= 1'b0;
            ovf     <= 1'b0;
            res_tag <= '0;
        end else begin
            accept  <= reply_hit && (word_q == PCOIN);
            reject  <= reply_hit && (word_q == NCOIN);
            timeout <= expire;
            ovf     <= ovf_nxt;
            if (pop_req) begin
                res_tag <= head_ent.tag[TAGW-1:0];
            end
        end
    end

`ifdef MCU_REPLY_STATS_EN
    logic        unsol;
    logic [15:0] code_err_q;
    logic [15:0] unsol_q;
    logic [15:0] timeout_q;

    always_comb begin
        unsol = reply_dec && !reply_hit;
    end

    // Saturating statistics counters; clear wins over increment.
    always_ff @(posedge clk) begin
        if (!rst_n || cnt_clr) begin
            code_err_q <= '0;
            unsol_q    <= '0;
            timeout_q  <= '0;
        end else begin
            if (code_err && (code_err_q != '1)) begin
                code_err_q <= code_err_q + 16'd1;
            end
            if (unsol && (unsol_q != '1)) begin
                unsol_q <= unsol_q + 16'd1;
            end
            if (expire && (timeout_q != '1)) begin
                timeout_q <= timeout_q + 16'd1;
            end
        end
    end

    assign code_err_cnt = code_err_q;
    assign unsol_cnt    = unsol_q;
    assign timeout_cnt  = timeout_q;
`else
    logic unused_cnt_clr;

    assign unused_cnt_clr = cnt_clr;
    assign code_err_cnt   = '0;
    assign unsol_cnt      = '0;
    assign timeout_cnt    = '0;
`endif

endmodule

// File: tb/tb_mcu_reply_rx.sv
// tb_mcu_reply_rx: directed table + sequences and a randomized run checked
// against a queue-based reference model of trig resolution and link lock.
module tb_mcu_reply_rx;

    localparam int unsigned LAT    = 6;
    localparam int unsigned TOL    = 1;
    localparam int unsigned DEPTH  = 8;
    localparam int unsigned TAGW   = 8;
    localparam int unsigned LOCK_N = 8;

    localparam logic [3:0] W_I0 = 4'b0111;
    localparam logic [3:0] W_I1 = 4'b1011;
    localparam logic [3:0] W_I2 = 4'b1101;
    localparam logic [3:0] W_I3 = 4'b1110;
    localparam logic [3:0] W_N  = 4'b1001;
    localparam logic [3:0] W_P  = 4'b0011;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [3:0]      mcu_in = 4'b0;
    logic            trig = 1'b0;
    logic [TAGW-1:0] trig_tag = '0;
    logic            cnt_clr = 1'b0;
    logic            locked, accept, reject, timeout, ovf;
    logic [TAGW-1:0] res_tag;
    logic [15:0]     code_err_cnt, unsol_cnt, timeout_cnt;

    always #5 clk = ~clk;

    mcu_reply_rx #(
        .REPLY_LAT (LAT),
        .REPLY_TOL (TOL),
        .DEPTH     (DEPTH),
        .TAGW      (TAGW),
        .LOCK_N    (LOCK_N)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .mcu_in       (mcu_in),
        .trig         (trig),
        .trig_tag     (trig_tag),
        .cnt_clr      (cnt_clr),
        .locked       (locked),
        .accept       (accept),
        .reject       (reject),
        .timeout      (timeout),
        .res_tag      (res_tag),
        .ovf          (ovf),
        .code_err_cnt (code_err_cnt),
        .unsol_cnt    (unsol_cnt),
        .timeout_cnt  (timeout_cnt)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct { int t; logic [7:0] tag; } pend_t;
    pend_t      pend[$];
    int         m;          // capture edges since reset release
    bit         lk;
    int         lcnt;
    logic [3:0] prevw;
    bit         prevk;
    logic [3:0] pw;
    bit         pwv;
    int         ce, us, to;
    bit         e_acc, e_rej, e_to, e_ovf;
    logic [7:0] e_tag;
    logic [3:0] lastw;

    function automatic int idle_idx(input logic [3:0] w);
        case (w)
            W_I0: return 0;
            W_I1: return 1;
            W_I2: return 2;
            W_I3: return 3;
            default: return -1;
        endcase
    endfunction

    function automatic bit is_rep(input logic [3:0] w);
        return (w == W_P) || (w == W_N);
    endfunction

    function automatic bit word_ok(input logic [3:0] p, input logic [3:0] c, input bit pk);
        if (idle_idx(c) < 0 && !is_rep(c)) return 0;
        if (!pk) return 1;
        if (idle_idx(p) >= 0) return (idle_idx(c) == (idle_idx(p) + 1) % 4) || is_rep(c);
        if (is_rep(p)) return c == W_I0;
        return 0;
    endfunction

    function automatic logic [3:0] next_idle(input logic [3:0] w);
        case (w)
            W_I0: return W_I1;
            W_I1: return W_I2;
            W_I2: return W_I3;
            default: return W_I0;
        endcase
    endfunction

    function automatic int sat_inc(input int v);
        return (v < 65535) ? v + 1 : v;
    endfunction

    task automatic model_reset();
        pend.delete();
        m = 0; lk = 0; lcnt = 0; prevk = 0; pwv = 0; prevw = 4'b0; pw = 4'b0;
        ce = 0; us = 0; to = 0;
        e_acc = 0; e_rej = 0; e_to = 0; e_ovf = 0; e_tag = 8'h00;
    endtask

    // One capture edge: resolve the previously captured word, then take this edge's trig.
    task automatic model_edge(input logic [3:0] w, input bit tr, input logic [7:0] tg, input bit clr);
        bit valid, reply, hit, expire;
        int age;
        pend_t h;
        m++;
        e_acc = 0; e_rej = 0; e_to = 0; e_ovf = 0;
        hit = 0; expire = 0;
        if (pwv) begin
            valid = word_ok(prevw, pw, prevk);
            reply = lk && valid && is_rep(pw);
            age   = (pend.size() > 0) ? (m - 1) - pend[0].t : -1;
            if (reply && pend.size() > 0 && age >= int'(LAT - TOL) && age <= int'(LAT + TOL)) hit = 1;
            if (!hit && pend.size() > 0 && age == int'(LAT + TOL + 1)) expire = 1;
            if (!clr) begin
                if (!valid) ce = sat_inc(ce);
                if (reply && !hit) us = sat_inc(us);
                if (expire) to = sat_inc(to);
            end
            if (!lk) begin
                if (valid) begin
                    lcnt++;
                    if (lcnt == int'(LOCK_N)) begin lk = 1; lcnt = 0; end
                end else lcnt = 0;
            end else if (!valid) begin
                lk = 0; lcnt = 0;
            end
            if (hit) begin
                h = pend.pop_front();
                e_tag = h.tag;
                if (pw == W_P) e_acc = 1; else e_rej = 1;
            end else if (expire) begin
                h = pend.pop_front();
                e_tag = h.tag;
                e_to = 1;
            end
            prevw = pw; prevk = 1;
        end
        if (clr) begin ce = 0; us = 0; to = 0; end
        if (tr) begin
            if (pend.size() < int'(DEPTH)) pend.push_back('{t: m, tag: tg});
            else e_ovf = 1;
        end
        pw = w; pwv = 1;
    endtask

    task automatic compare_all();
        chk("locked", int'(locked), int'(lk));
        chk("accept", int'(accept), int'(e_acc));
        chk("reject", int'(reject), int'(e_rej));
        chk("timeout", int'(timeout), int'(e_to));
        chk("ovf", int'(ovf), int'(e_ovf));
        chk("res_tag", int'(res_tag), int'(e_tag));
`ifdef MCU_REPLY_STATS_EN
        chk("code_err_cnt", int'(code_err_cnt), ce);
        chk("unsol_cnt", int'(unsol_cnt), us);
        chk("timeout_cnt", int'(timeout_cnt), to);
`else
        chk("code_err_cnt_off", int'(code_err_cnt), 0);
        chk("unsol_cnt_off", int'(unsol_cnt), 0);
        chk("timeout_cnt_off", int'(timeout_cnt), 0);
`endif
    endtask

    task automatic step(input logic [3:0] w, input bit tr, input logic [7:0] tg, input bit clr);
        mcu_in   = w;
        trig     = tr;
        trig_tag = tg;
        cnt_clr  = clr;
        @(posedge clk);
        model_edge(w, tr, tg, clr);
        lastw = w;
        #1;
        compare_all();
        trig = 1'b0;
        cnt_clr = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(next_idle(lastw), 0, 8'h00, 0);
    endtask

    task automatic do_reset(input int n);
        rst_n = 1'b0;
        trig  = 1'b0;
        repeat (n) @(posedge clk);
        #1;
        chk("rst_locked", int'(locked), 0);
        chk("rst_accept", int'(accept), 0);
        chk("rst_reject", int'(reject), 0);
        chk("rst_timeout", int'(timeout), 0);
        chk("rst_ovf", int'(ovf), 0);
        chk("rst_res_tag", int'(res_tag), 0);
        chk("rst_code_err_cnt", int'(code_err_cnt), 0);
        chk("rst_unsol_cnt", int'(unsol_cnt), 0);
        chk("rst_timeout_cnt", int'(timeout_cnt), 0);
        model_reset();
        lastw = W_I3;
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic [3:0] w;
        bit         tr;
        logic [7:0] tag;
        bit         e_locked;
        bit         e_accept;
        logic [7:0] e_res_tag;
    } vec_t;

    vec_t tbl[18];

    initial begin
        int k_seen;
        logic [7:0] tag_seen;
        logic [7:0] got[$];
        int n_acc, n_rej, n_to;
        logic [3:0] wseq[8];
        logic [3:0] w;
        bit tr;
        int r, age;

        wseq = '{W_I0, W_I1, W_I2, W_I3, W_I0, W_I1, W_I2, W_I3};
        for (int i = 0; i < 18; i++) begin
            tbl[i].w         = (i < 8) ? wseq[i] : wseq[i % 4];
            tbl[i].tr        = (i == 9);
            tbl[i].tag       = (i == 9) ? 8'h5A : 8'h00;
            tbl[i].e_locked  = (i >= 8);
            tbl[i].e_accept  = (i == 16);
            tbl[i].e_res_tag = (i >= 16) ? 8'h5A : 8'h00;
        end
        tbl[15].w = W_P;     // PCOIN captured 6 edges after the trig
        tbl[16].w = W_I0;
        tbl[17].w = W_I1;

        model_reset();
        do_reset(3);

        // Lock acquisition and a matched PCOIN.
        for (int i = 0; i < 18; i++) begin
            step(tbl[i].w, tbl[i].tr, tbl[i].tag, 0);
            chk("tbl_locked", int'(locked), int'(tbl[i].e_locked));
            chk("tbl_accept", int'(accept), int'(tbl[i].e_accept));
            chk("tbl_res_tag", int'(res_tag), int'(tbl[i].e_res_tag));
        end
        chk("lock_code_err_cnt", int'(code_err_cnt), 0);
        n_to = 0;
        for (int i = 0; i < 12; i++) begin
            idle(1);
            if (timeout) n_to++;
        end
        chk("fifo_empty_after_accept", n_to, 0);

        // Unanswered trig times out.
        step(next_idle(lastw), 1, 8'h11, 0);
        k_seen = -1; tag_seen = 8'h00;
        for (int k = 1; k <= 20; k++) begin
            idle(1);
            if (timeout === 1'b1 && k_seen < 0) begin k_seen = k; tag_seen = res_tag; end
        end
        chk("timeout_latency", k_seen, 9);
        chk("timeout_tag", int'(tag_seen), 8'h11);
`ifdef MCU_REPLY_STATS_EN
        chk("timeout_cnt_one", int'(timeout_cnt), 1);
`else
        chk("timeout_cnt_off_one", int'(timeout_cnt), 0);
`endif

        // Code error drops lock; NCOIN before relock is ignored.
        for (int i = 0; i < 4 && lastw != W_I0; i++) idle(1);
        step(W_I1, 1, 8'h33, 0);
        step(W_I3, 0, 8'h00, 0);
        chk("err_locked_still", int'(locked), 1);
        step(W_I0, 0, 8'h00, 0);
        chk("err_locked_drop", int'(locked), 0);
`ifdef MCU_REPLY_STATS_EN
        chk("err_code_err_cnt", int'(code_err_cnt), 1);
`endif
        idle(3);
        step(W_N, 0, 8'h00, 0);
        n_rej = 0; k_seen = 0; tag_seen = 8'h00;
        for (int i = 0; i < 8; i++) begin
            idle(1);
            if (reject) n_rej++;
            if (timeout) begin k_seen++; tag_seen = res_tag; end
        end
        chk("hunt_no_reject", n_rej, 0);
        chk("hunt_timeout_seen", k_seen, 1);
        chk("hunt_timeout_tag", int'(tag_seen), 8'h33);
        idle(12);
        chk("relocked", int'(locked), 1);

        // Nine back-to-back trigs: the ninth overflows, eight time out in order.
        for (int i = 0; i < 9; i++) begin
            step(next_idle(lastw), 1, 8'hA0 + 8'(i), 0);
            if (i == 7) chk("ovf_eighth", int'(ovf), 0);
            if (i == 8) chk("ovf_ninth", int'(ovf), 1);
        end
        got.delete();
        for (int i = 0; i < 40; i++) begin
            idle(1);
            if (timeout) got.push_back(res_tag);
        end
        chk("ovf_timeouts", got.size(), 8);
        for (int i = 0; i < 8 && i < got.size(); i++) chk("ovf_timeout_order", int'(got[i]), 8'hA0 + i);

        // Spaced trigs answered by NCOIN at age 6.
        idle(12);
        got.delete();
        for (int e = 0; e <= 16; e++) begin
            if (e >= 6 && e <= 12 && e % 2 == 0) w = W_N;
            else if (e >= 7 && e <= 13 && e % 2 == 1) w = W_I0;
            else w = next_idle(lastw);
            tr = (e % 2 == 0) && (e <= 6);
            step(w, tr, 8'hB0 + 8'(e / 2), 0);
            if (reject) got.push_back(res_tag);
        end
        chk("reject_count", got.size(), 4);
        for (int i = 0; i < 4 && i < got.size(); i++) chk("reject_order", int'(got[i]), 8'hB0 + i);

        // Reply with nothing pending.
        idle(4);
        for (int i = 0; i < 4 && lastw != W_I2; i++) idle(1);
        step(W_P, 0, 8'h00, 0);
        step(W_I0, 0, 8'h00, 0);
        chk("unsol_no_accept", int'(accept), 0);
        chk("unsol_no_reject", int'(reject), 0);

        // Statistics clear.
        step(next_idle(lastw), 0, 8'h00, 1);
        chk("clr_code_err_cnt", int'(code_err_cnt), 0);
        chk("clr_unsol_cnt", int'(unsol_cnt), 0);
        chk("clr_timeout_cnt", int'(timeout_cnt), 0);

        // Reset mid-stream with a trig pending; it must vanish silently.
        step(next_idle(lastw), 1, 8'h77, 0);
        idle(2);
        do_reset(1);
        n_to = 0;
        for (int i = 0; i < 20; i++) begin
            idle(1);
            if (timeout) n_to++;
        end
        chk("reset_discards_pending", n_to, 0);

        // Randomized traffic.
        do_reset(2);
        n_acc = 0; n_rej = 0; n_to = 0;
        for (int c = 0; c < 3000; c++) begin
            r = int'($urandom_range(0, 99));
            age = (pend.size() > 0) ? (m + 1) - pend[0].t : -1;
            if (r < 3) w = 4'($urandom_range(0, 15));
            else if (idle_idx(lastw) >= 0 && age >= 4 && age <= 8 && r < 70) w = ($urandom_range(0, 1) != 0) ? W_P : W_N;
            else if (idle_idx(lastw) >= 0 && r < 12) w = ($urandom_range(0, 1) != 0) ? W_P : W_N;
            else w = next_idle(lastw);
            step(w, $urandom_range(0, 4) == 0, 8'($urandom_range(0, 255)), $urandom_range(0, 199) == 0);
            if (accept) n_acc++;
            if (reject) n_rej++;
            if (timeout) n_to++;
        end
        $display("random traffic: %0d accept, %0d reject, %0d timeout", n_acc, n_rej, n_to);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
